// File: rtl/fp16_pkg.sv
// Shared FP16 constants and types for the log-multiplier result stage:
// format parameters, operand classes, serializer FSM states and flag bit positions.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    FIXUP    = 3'd2,
    SEND_LO  = 3'd3,
    SEND_HI  = 3'd4
  } state_e;

  localparam int FLAG_NAN   = 0;
  localparam int FLAG_INF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_RANGE = 3;

endpackage

// File: rtl/fp16_result_fixup_serializer_if.sv
// Operand/raw-product capture handshake and the outgoing byte stream of the fixup serializer.
interface fp16_result_fixup_serializer_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        raw_sign;
  logic [6:0]  raw_exp;
  logic [9:0]  raw_man;

  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport slave (
    input  in_valid, op_a, op_b, raw_sign, raw_exp, raw_man, out_ready,
    output in_ready, out_byte, out_valid, out_last
  );

  modport master (
    output in_valid, op_a, op_b, raw_sign, raw_exp, raw_man, out_ready,
    input  in_ready, out_byte, out_valid, out_last
  );

endinterface

// File: rtl/fp16_result_fixup_serializer_classify.sv
// Combinational FP16 operand classifier; subnormals are treated as zero.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0] value,
  output fp_class_e   cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = value[EXP_W+MAN_W-1:MAN_W];
  assign man_f       = value[MAN_W-1:0];
  assign unused_sign = value[15];

  // NOTE: cls gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == EXP_W'(EXP_MAX)) begin
      cls = (man_f == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp16_result_fixup_serializer.sv
// Applies special-case and range fixups to the approximate FP16 product and
// serializes the corrected result as two bytes, low byte first.
module fp16_result_fixup_serializer #(
  parameter int EXP_W = fp16_pkg::EXP_W,
  parameter int MAN_W = fp16_pkg::MAN_W,
  parameter int BIAS  = fp16_pkg::BIAS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fp16_result_fixup_serializer_if.slave bus,
  output logic [3:0]                    flags
);
  import fp16_pkg::*;

  // Port widths are fixed to binary16, so only the standard format is meaningful.
  if (1 + EXP_W + MAN_W != 16 || BIAS != (1 << (EXP_W - 1)) - 1) begin : g_bad_format
    $error("fp16_result_fixup_serializer supports only the binary16 format");
  end

  localparam logic signed [6:0] OVF_EXP = 7'((1 << EXP_W) - 1);

  state_e      state_q, state_d;
  logic [15:0] op_a_q, op_b_q;
  logic        raw_sign_q;
  logic [6:0]  raw_exp_q;
  logic [9:0]  raw_man_q;
  fp_class_e   cls_a_d, cls_b_d, cls_a_q, cls_b_q;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_d;
  logic        any_nan, any_inf, any_zero;

  fp16_classify u_classify_a (.value(op_a_q), .cls(cls_a_d));
  fp16_classify u_classify_b (.value(op_b_q), .cls(cls_b_d));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decode only the registered state; inputs steer state_d alone.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_byte  = '0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CLASSIFY;
      end
      CLASSIFY: state_d = FIXUP;
      FIXUP:    state_d = SEND_LO;
      SEND_LO: begin
        bus.out_valid = 1'b1;
        bus.out_byte  = result_q[7:0];
        if (bus.out_ready) state_d = SEND_HI;
      end
      SEND_HI: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_byte  = result_q[15:8];
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign any_nan  = (cls_a_q == NAN)  || (cls_b_q == NAN);
  assign any_inf  = (cls_a_q == INF)  || (cls_b_q == INF);
  assign any_zero = (cls_a_q == ZERO) || (cls_b_q == ZERO);

  // Priority chain: invalid operations, then operand specials, then exponent range.
  always_comb begin
    result_d = {raw_sign_q, raw_exp_q[EXP_W-1:0], raw_man_q[MAN_W-1:0]};
    flags_d  = '0;
    if (any_nan || (any_inf && any_zero)) begin
      result_d          = QNAN;
      flags_d[FLAG_NAN] = 1'b1;
    end else if (any_inf) begin
      result_d          = {raw_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLAG_INF] = 1'b1;
    end else if (any_zero) begin
      result_d           = {raw_sign_q, {(EXP_W + MAN_W){1'b0}}};
      flags_d[FLAG_ZERO] = 1'b1;
    end else if ($signed(raw_exp_q) >= OVF_EXP) begin
      result_d            = {raw_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLAG_INF]   = 1'b1;
      flags_d[FLAG_RANGE] = 1'b1;
    end else if ($signed(raw_exp_q) <= 7'sd0) begin
      result_d            = {raw_sign_q, {(EXP_W + MAN_W){1'b0}}};
      flags_d[FLAG_ZERO]  = 1'b1;
      flags_d[FLAG_RANGE] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      raw_sign_q <= 1'b0;
      raw_exp_q  <= '0;
      raw_man_q  <= '0;
      cls_a_q    <= ZERO;
      cls_b_q    <= ZERO;
      result_q   <= '0;
      flags      <= '0;
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        op_a_q     <= bus.op_a;
        op_b_q     <= bus.op_b;
        raw_sign_q <= bus.raw_sign;
        raw_exp_q  <= bus.raw_exp;
        raw_man_q  <= bus.raw_man;
      end
      if (state_q == CLASSIFY) begin
        cls_a_q <= cls_a_d;
        cls_b_q <= cls_b_d;
      end
      if (state_q == FIXUP) begin
        result_q <= result_d;
        flags    <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp16_result_fixup_serializer.sv
// Directed bench for the FP16 fixup serializer: a rule-level product model feeds a byte
// scoreboard checked every output cycle, plus hand-computed literals from the test plan.
module tb_fp16_result_fixup_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags;

  fp16_result_fixup_serializer_if bus ();

  fp16_result_fixup_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [3:0] f;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [19:0] mdl;
  logic [7:0]  got_lo, got_hi;
  logic [3:0]  got_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result rules stated on decoded fields: returns {flags, result}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic [6:0] e, input logic [9:0] m);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    bit a_nan  = (ea == 31) && (a[9:0] != 0);
    bit b_nan  = (eb == 31) && (b[9:0] != 0);
    bit a_inf  = (ea == 31) && (a[9:0] == 0);
    bit b_inf  = (eb == 31) && (b[9:0] == 0);
    bit a_zero = (ea == 0);
    bit b_zero = (eb == 0);
    int re     = int'($signed(e));
    if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) return {4'b0001, 16'h7E00};
    if (a_inf || b_inf)   return {4'b0010, s, 5'h1F, 10'h000};
    if (a_zero || b_zero) return {4'b0100, s, 15'h0000};
    if (re >= 31)         return {4'b1010, s, 5'h1F, 10'h000};
    if (re <= 0)          return {4'b1100, s, 15'h0000};
    return {4'b0000, s, e[4:0], m};
  endfunction

  // Scoreboard: inputs only change #1 after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        mdl = model(bus.op_a, bus.op_b, bus.raw_sign, bus.raw_exp, bus.raw_man);
        exp_q.push_back('{b: mdl[7:0],  last: 1'b0, f: mdl[19:16]});
        exp_q.push_back('{b: mdl[15:8], last: 1'b1, f: mdl[19:16]});
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h with no byte outstanding (t=%0t)", bus.out_byte, $time);
        end else begin
          check("sb_out_byte", 32'(bus.out_byte), 32'(exp_q[0].b));
          check("sb_out_last", 32'(bus.out_last), 32'(exp_q[0].last));
          check("sb_flags",    32'(flags),        32'(exp_q[0].f));
          check("sb_in_ready", 32'(bus.in_ready), 32'd0);
          if (bus.out_ready) begin
            if (bus.out_last) begin
              got_hi    = bus.out_byte;
              got_flags = flags;
            end else begin
              got_lo = bus.out_byte;
            end
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [6:0] e, input logic [9:0] m);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_ready_wait", 32'(n < 100), 32'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.raw_sign = s;
    bus.raw_exp  = e;
    bus.raw_man  = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.in_ready && exp_q.size() == 0) && n < 100);
    check({name, "_done"}, 32'(n < 100), 32'd1);
  endtask

  task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic [6:0] e, input logic [9:0] m,
                     input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] f);
    got_lo    = 8'hEE;
    got_hi    = 8'hEE;
    got_flags = 4'hE;
    send(a, b, s, e, m);
    wait_done(name);
    check({name, "_lo"},    32'(got_lo),    32'(lo));
    check({name, "_hi"},    32'(got_hi),    32'(hi));
    check({name, "_flags"}, 32'(got_flags), 32'(f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.raw_sign  = 1'b0;
    bus.raw_exp   = '0;
    bus.raw_man   = '0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_byte",  32'(bus.out_byte),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_flags",     32'(flags),         32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency with out_ready high: capture edge T, bytes transfer at T+3 and T+4.
    got_lo = 8'hEE;
    got_hi = 8'hEE;
    send(16'h3C00, 16'h4000, 1'b0, 7'd16, 10'h000);
    @(negedge clk); check("lat_t0_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_t2_valid", 32'(bus.out_valid), 32'd1);
                    check("lat_t2_byte",  32'(bus.out_byte),  32'h00);
                    check("lat_t2_last",  32'(bus.out_last),  32'd0);
    @(negedge clk); check("lat_t3_valid", 32'(bus.out_valid), 32'd1);
                    check("lat_t3_byte",  32'(bus.out_byte),  32'h40);
                    check("lat_t3_last",  32'(bus.out_last),  32'd1);
    @(negedge clk); check("lat_t4_valid", 32'(bus.out_valid), 32'd0);
                    check("lat_t4_ready", 32'(bus.in_ready),  32'd1);
                    check("lat_flags",    32'(flags),         32'd0);
    @(posedge clk);
    #1;

    run("one_x_two",   16'h3C00, 16'h4000, 1'b0, 7'd16,  10'h000, 8'h00, 8'h40, 4'b0000);
    run("inf_x_zero",  16'h7C00, 16'h0000, 1'b0, 7'd16,  10'h000, 8'h00, 8'h7E, 4'b0001);
    run("neg_inf",     16'hFC00, 16'h3C00, 1'b1, 7'd30,  10'h000, 8'h00, 8'hFC, 4'b0010);
    run("nan_operand", 16'h7E01, 16'h3C00, 1'b1, 7'd15,  10'h000, 8'h00, 8'h7E, 4'b0001);
    run("zero_x_nan",  16'h0000, 16'h7C01, 1'b0, 7'd15,  10'h000, 8'h00, 8'h7E, 4'b0001);
    run("subnormal",   16'h0001, 16'h3C00, 1'b0, 7'd1,   10'h000, 8'h00, 8'h00, 4'b0100);
    run("exp_30",      16'h3C00, 16'h3C00, 1'b0, 7'd30,  10'h3FF, 8'hFF, 8'h7B, 4'b0000);
    run("exp_31",      16'h3C00, 16'h3C00, 1'b0, 7'd31,  10'h005, 8'h00, 8'h7C, 4'b1010);
    run("exp_1",       16'h3C00, 16'h3C00, 1'b1, 7'd1,   10'h155, 8'h55, 8'h85, 4'b0000);
    run("exp_0",       16'h3C00, 16'h3C00, 1'b0, 7'd0,   10'h155, 8'h00, 8'h00, 4'b1100);
    run("overflow",    16'h7800, 16'h7800, 1'b0, 7'd44,  10'h000, 8'h00, 8'h7C, 4'b1010);
    run("underflow",   16'h0400, 16'h0400, 1'b1, 7'h71,  10'h000, 8'h00, 8'h80, 4'b1100);

    // Backpressure: hold SEND_LO for four cycles and pulse in_valid into the busy block.
    got_lo = 8'hEE;
    got_hi = 8'hEE;
    bus.out_ready = 1'b0;
    send(16'h3C00, 16'h3E00, 1'b0, 7'd15, 10'h2AB);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.out_valid && n < 20);
      check("bp_valid_seen", 32'(n < 20), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i == 1);
      bus.op_a     = 16'h7C00;
      bus.op_b     = 16'h0000;
      @(negedge clk);
      check("bp_valid",    32'(bus.out_valid), 32'd1);
      check("bp_byte",     32'(bus.out_byte),  32'hAB);
      check("bp_last",     32'(bus.out_last),  32'd0);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_done("bp");
    check("bp_lo",    32'(got_lo),    32'hAB);
    check("bp_hi",    32'(got_hi),    32'h3E);
    check("bp_flags", 32'(got_flags), 32'd0);

    // Reset in FIXUP after an underflow left flags nonzero.
    run("pre_reset", 16'h0400, 16'h0400, 1'b1, 7'h71, 10'h000, 8'h00, 8'h80, 4'b1100);
    @(posedge clk);
    #1;
    send(16'h7800, 16'h7800, 1'b0, 7'd44, 10'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags",     32'(flags),         32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_byte",  32'(bus.out_byte),  32'd0);
    check("mid_rst_out_last",  32'(bus.out_last),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    end
    @(posedge clk);
    #1;
    run("after_reset", 16'h3C00, 16'h4000, 1'b0, 7'd16, 10'h000, 8'h00, 8'h40, 4'b0000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
